// File: rtl/matrix_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_bram_stream_reader
// Purpose  : Avalon-MM read initiator for port s2 of the matrix data BRAM.
//            Fetches a run of 32-bit words starting at a base address, splits
//            each word into 8-bit elements (byte 0 first) and streams them on
//            a valid/ready interface into the systolic array skew buffers.
// Options  : MATRIX_BRAM_READER_PREFETCH_EN - adds a second word register and
//            overlaps the next BRAM read with the current word's last bytes,
//            giving one element per cycle when the sink never stalls.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_bram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int ELEM_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_address,
    output logic              bram_chipselect,
    output logic              bram_write,
    output logic [3:0]        bram_byteenable,
    output logic              bram_clken,
    input  logic [DATA_W-1:0] bram_readdata,
    output logic [ELEM_W-1:0] elem_data,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic              elem_last
);

    localparam int                NUM_ELEMS = 4;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W + 1)'(1);
    localparam logic [1:0]        LAST_BYTE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     idx_q;
    logic [DATA_W-1:0]   word_q;
    logic [1:0]          byte_sel;
    logic [ELEM_W-1:0]   word_elems [NUM_ELEMS];
    logic                last_word;

    // The read port is read-only and always clocked.
    assign bram_write      = 1'b0;
    assign bram_byteenable = 4'hF;
    assign bram_clken      = 1'b1;

    // idx is one bit wider than the address, so a 16-word run terminates
    // correctly even though the address itself wraps.
    assign last_word = ((idx_q + IDX_ONE) == count_q);

    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_split
            assign word_elems[gi] = word_q[gi*ELEM_W +: ELEM_W];
        end
    endgenerate

`ifdef MATRIX_BRAM_READER_PREFETCH_EN
    logic              pf_issue;
    logic              pf_pending;
    logic [DATA_W-1:0] pf_hold;
    logic [DATA_W-1:0] pf_word;

    // The next word is requested as byte 2 leaves, unless this is the final word.
    assign pf_issue = (state == S_EMIT) && elem_ready && (byte_sel == 2'd2) && !last_word;
    // Freshly returned data bypasses the hold register so byte 3 can hand over
    // to the next word without a bubble.
    assign pf_word  = pf_pending ? bram_readdata : pf_hold;

    // Capture the prefetched word the cycle it returns and keep it across a byte-3 stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_pending <= 1'b0;
            pf_hold    <= '0;
        end else begin
            pf_pending <= pf_issue;
            if (pf_pending) begin
                pf_hold <= bram_readdata;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore/handshake outputs.
    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        bram_chipselect = 1'b0;
        bram_address    = '0;
        elem_valid      = 1'b0;
        elem_last       = 1'b0;
        elem_data       = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (word_count != '0) ? S_ISSUE : S_FINISH;
                end
            end
            S_ISSUE: begin
                busy            = 1'b1;
                bram_chipselect = 1'b1;
                bram_address    = base_q + idx_q[ADDR_W-1:0];
                state_nxt       = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy       = 1'b1;
                elem_valid = 1'b1;
                elem_data  = word_elems[byte_sel];
                elem_last  = (byte_sel == LAST_BYTE) && last_word;
`ifdef MATRIX_BRAM_READER_PREFETCH_EN
                if (pf_issue) begin
                    bram_chipselect = 1'b1;
                    bram_address    = base_q + idx_q[ADDR_W-1:0] + ADDR_ONE;
                end
                if (elem_ready && (byte_sel == LAST_BYTE)) begin
                    state_nxt = last_word ? S_FINISH : S_EMIT;
                end
`else
                if (elem_ready && (byte_sel == LAST_BYTE)) begin
                    state_nxt = last_word ? S_FINISH : S_ISSUE;
                end
`endif
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: latch the request, load words, advance byte and word counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q   <= '0;
            count_q  <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            byte_sel <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        idx_q   <= '0;
                    end
                end
                S_CAPTURE: begin
                    word_q   <= bram_readdata;
                    byte_sel <= 2'd0;
                end
                S_EMIT: begin
                    if (elem_ready) begin
                        byte_sel <= byte_sel + 2'd1;
                        if (byte_sel == LAST_BYTE) begin
                            idx_q <= idx_q + IDX_ONE;
`ifdef MATRIX_BRAM_READER_PREFETCH_EN
                            if (!last_word) begin
                                word_q <= pf_word;
                            end
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
